// File: rtl/fpu_pkg.sv
// Shared FPU definitions: datapath widths, the fpuOp encoding used by the
// stall controller and decode, and the write-back entry layout.
package fpu_pkg;

  localparam int FP_DATA_W = 32;
  localparam int FP_RD_W   = 5;

  // fpuOp encoding, shared with the FPU stall controller
  localparam logic [3:0] FPU_OP_ADD     = 4'h0;
  localparam logic [3:0] FPU_OP_SUB     = 4'h1;
  localparam logic [3:0] FPU_OP_MUL     = 4'h2;
  localparam logic [3:0] FPU_OP_DIV     = 4'h3;
  localparam logic [3:0] FPU_OP_SQRT    = 4'h4;
  localparam logic [3:0] FPU_OP_CMP     = 4'h5;
  localparam logic [3:0] FPU_OP_CVT_F2I = 4'h6;
  localparam logic [3:0] FPU_OP_CVT_I2F = 4'h7;
  localparam logic [3:0] FPU_OP_MOV_F2I = 4'h8;
  localparam logic [3:0] FPU_OP_MOV_I2F = 4'h9;

  // Write-back entry, packed MSB-first as {fp_dest, rd, data}
  typedef struct packed {
    logic                 fp_dest;
    logic [FP_RD_W-1:0]   rd;
    logic [FP_DATA_W-1:0] data;
  } fpu_wb_entry_t;

  localparam int FP_ENTRY_W = $bits(fpu_wb_entry_t);

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic circular FIFO for pending FPU results. Keeps an explicit occupancy
// count and a per-slot valid vector so the owner can scan every live entry.
module fpu_wb_fifo
  import fpu_pkg::*;
#(
  parameter int WIDTH = FP_ENTRY_W,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_wdata,
  output logic [WIDTH-1:0]             o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [CNT_W-1:0]             o_count,
  output logic [PTR_W-1:0]             o_rd_ptr,
  output logic [DEPTH-1:0]             o_valid,
  output logic [DEPTH-1:0][WIDTH-1:0]  o_entries
);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]            r_count;
  logic [DEPTH-1:0]            r_valid;
  logic                        w_do_push;
  logic                        w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_rd_ptr  = r_rd_ptr;
  assign o_valid   = r_valid;
  assign o_entries = r_mem;

  // Entry storage: written on every accepted push
  // NOTE: the storage array has no reset; r_valid and r_count decide what is live, so stale contents are harmless.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, count and valid vector; clear wins over any push or pop
  // NOTE: non-blocking assignments throughout sequential logic; the later valid write below intentionally overrides the earlier one when both pointers coincide.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_do_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_wb_buffer.sv
// FPU write-back buffer: captures each FPU result in its final EX cycle,
// queues it, and drains it in order to the FP or integer write port when
// that port is not claimed by its priority user. Also forwards pending
// results to ID/EX and reports occupancy/backpressure to the hazard unit.
module fpu_wb_buffer
  import fpu_pkg::*;
#(
  parameter int DATA_W = FP_DATA_W,
  parameter int RD_W   = FP_RD_W,
  parameter int DEPTH  = 2
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic                         fpu_sel,
  input  logic                         fpu_inprogress,
  input  logic                         ex_hold,
  input  logic [DATA_W-1:0]            fpu_result,
  input  logic [RD_W-1:0]              fpu_rd,
  input  logic                         fpu_fp_dest,
  input  logic                         load_fp_wr,
  input  logic                         int_port_busy,
  input  logic [RD_W-1:0]              query_rd,
  input  logic                         query_fp,
  output logic                         wb_fp_en,
  output logic                         wb_int_en,
  output logic [RD_W-1:0]              wb_rd,
  output logic [DATA_W-1:0]            wb_data,
  output logic                         query_hit,
  output logic [DATA_W-1:0]            query_data,
  output logic                         buf_full,
  output logic [$clog2(DEPTH+1)-1:0]   buf_count,
  output logic                         overflow
);

  localparam int ENTRY_W = 1 + RD_W + DATA_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic                          w_push;
  logic                          w_pop;
  logic [ENTRY_W-1:0]            w_wdata;
  logic [ENTRY_W-1:0]            w_head;
  logic                          w_full;
  logic                          w_empty;
  logic [CNT_W-1:0]              w_count;
  logic [PTR_W-1:0]              w_rd_ptr;
  logic [DEPTH-1:0]              w_valid;
  logic [DEPTH-1:0][ENTRY_W-1:0] w_entries;
  logic                          w_head_fp;
  logic [RD_W-1:0]               w_head_rd;
  logic [DATA_W-1:0]             w_head_data;
  logic                          w_query_ok;
  logic [PTR_W-1:0]              w_idx;
  logic                          r_overflow;

  // Exactly one push per FPU instruction: its last EX cycle, not held
  assign w_push  = fpu_sel & ~fpu_inprogress & ~ex_hold;
  assign w_wdata = {fpu_fp_dest, fpu_rd, fpu_result};

  fpu_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .clear     (clear),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   (w_wdata),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_rd_ptr  (w_rd_ptr),
    .o_valid   (w_valid),
    .o_entries (w_entries)
  );

  assign w_head_fp   = w_head[ENTRY_W-1];
  assign w_head_rd   = w_head[DATA_W +: RD_W];
  assign w_head_data = w_head[DATA_W-1:0];

  // Head drains only when its own port is free; younger entries wait behind it
  assign w_pop = ~w_empty & (w_head_fp ? ~load_fp_wr : ~int_port_busy);

  assign wb_fp_en  = w_pop & w_head_fp;
  assign wb_int_en = w_pop & ~w_head_fp & (w_head_rd != '0);
  assign wb_rd     = w_empty ? '0 : w_head_rd;
  assign wb_data   = w_empty ? '0 : w_head_data;

  assign buf_full  = w_full;
  assign buf_count = w_count;
  assign overflow  = r_overflow;

  // Sticky flag for a result dropped because the buffer was full and not draining
  always_ff @(posedge clock) begin
    if (clear) begin
      r_overflow <= 1'b0;
    end else if (w_push & w_full & ~w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // Integer x0 is never a forwarding source
  assign w_query_ok = query_fp | (query_rd != '0);

  // Forwarding scan from oldest to youngest so the youngest match is kept last
  // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    query_hit  = 1'b0;
    query_data = '0;
    w_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_rd_ptr + PTR_W'(k);
      if (w_query_ok && w_valid[w_idx] &&
          (w_entries[w_idx][ENTRY_W-1] == query_fp) &&
          (w_entries[w_idx][DATA_W +: RD_W] == query_rd)) begin
        query_hit  = 1'b1;
        query_data = w_entries[w_idx][DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Self-checking bench for fpu_wb_buffer: directed scenario tasks plus a
// scoreboard monitor that predicts every write-back, occupancy and lookup.
module tb_fpu_wb_buffer;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              clear;
  logic              fpu_sel, fpu_inprogress, ex_hold, fpu_fp_dest;
  logic [DATA_W-1:0] fpu_result;
  logic [RD_W-1:0]   fpu_rd;
  logic              load_fp_wr, int_port_busy;
  logic [RD_W-1:0]   query_rd;
  logic              query_fp;
  logic              wb_fp_en, wb_int_en;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              query_hit;
  logic [DATA_W-1:0] query_data;
  logic              buf_full;
  logic [CNT_W-1:0]  buf_count;
  logic              overflow;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic              fp;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t sb[$];
  ent_t mon_new;
  logic m_ovf = 1'b0;
  bit   mon_en = 1'b0;

  logic              mon_pop, mon_fp, mon_fp_en, mon_int_en, mon_hit, mon_push;
  logic [RD_W-1:0]   mon_rd;
  logic [DATA_W-1:0] mon_data, mon_qdata;
  logic [CNT_W-1:0]  mon_cnt;

  always #5 clock = ~clock;

  fpu_wb_buffer #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .clear          (clear),
    .fpu_sel        (fpu_sel),
    .fpu_inprogress (fpu_inprogress),
    .ex_hold        (ex_hold),
    .fpu_result     (fpu_result),
    .fpu_rd         (fpu_rd),
    .fpu_fp_dest    (fpu_fp_dest),
    .load_fp_wr     (load_fp_wr),
    .int_port_busy  (int_port_busy),
    .query_rd       (query_rd),
    .query_fp       (query_fp),
    .wb_fp_en       (wb_fp_en),
    .wb_int_en      (wb_int_en),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .query_hit      (query_hit),
    .query_data     (query_data),
    .buf_full       (buf_full),
    .buf_count      (buf_count),
    .overflow       (overflow)
  );

  // Scoreboard monitor: mid-cycle, predict outputs from the queue, then apply the coming edge
  always @(negedge clock) begin
    if (mon_en) begin
      mon_pop = 1'b0; mon_fp = 1'b0; mon_rd = '0; mon_data = '0;
      if (sb.size() != 0) begin
        mon_fp   = sb[0].fp;
        mon_rd   = sb[0].rd;
        mon_data = sb[0].data;
        mon_pop  = mon_fp ? !load_fp_wr : !int_port_busy;
      end
      mon_fp_en  = mon_pop && mon_fp;
      mon_int_en = mon_pop && !mon_fp && (mon_rd != 0);
      mon_cnt    = CNT_W'(sb.size());
      mon_hit = 1'b0; mon_qdata = '0;
      if (query_fp || query_rd != 0) begin
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].fp == query_fp && sb[i].rd == query_rd) begin
            mon_hit = 1'b1; mon_qdata = sb[i].data;
          end
        end
      end
      n_cmp++; if (wb_fp_en !== mon_fp_en) begin n_mis++; $display("FAIL sb_wb_fp_en t=%0t: got %b want %b", $time, wb_fp_en, mon_fp_en); end
      n_cmp++; if (wb_int_en !== mon_int_en) begin n_mis++; $display("FAIL sb_wb_int_en t=%0t: got %b want %b", $time, wb_int_en, mon_int_en); end
      n_cmp++; if (wb_rd !== mon_rd) begin n_mis++; $display("FAIL sb_wb_rd t=%0t: got %0d want %0d", $time, wb_rd, mon_rd); end
      n_cmp++; if (wb_data !== mon_data) begin n_mis++; $display("FAIL sb_wb_data t=%0t: got %h want %h", $time, wb_data, mon_data); end
      n_cmp++; if (buf_count !== mon_cnt) begin n_mis++; $display("FAIL sb_count t=%0t: got %0d want %0d", $time, buf_count, mon_cnt); end
      n_cmp++; if (buf_full !== (sb.size() == DEPTH)) begin n_mis++; $display("FAIL sb_full t=%0t: got %b want %b", $time, buf_full, sb.size() == DEPTH); end
      n_cmp++; if (overflow !== m_ovf) begin n_mis++; $display("FAIL sb_overflow t=%0t: got %b want %b", $time, overflow, m_ovf); end
      n_cmp++; if (query_hit !== mon_hit) begin n_mis++; $display("FAIL sb_query_hit t=%0t: got %b want %b", $time, query_hit, mon_hit); end
      if (mon_hit || sb.size() == 0) begin
        n_cmp++; if (query_data !== mon_qdata) begin n_mis++; $display("FAIL sb_query_data t=%0t: got %h want %h", $time, query_data, mon_qdata); end
      end
      mon_push = fpu_sel && !fpu_inprogress && !ex_hold;
      if (clear) begin
        sb.delete();
        m_ovf = 1'b0;
      end else begin
        if (mon_pop) void'(sb.pop_front());
        if (mon_push) begin
          if (sb.size() < DEPTH) begin
            mon_new.fp = fpu_fp_dest; mon_new.rd = fpu_rd; mon_new.data = fpu_result;
            sb.push_back(mon_new);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    mid();
    n_cmp++; if (buf_count !== '0) begin n_mis++; $display("FAIL reset_count: got %0d want 0", buf_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (wb_fp_en !== 1'b0 || wb_int_en !== 1'b0) begin n_mis++; $display("FAIL reset_wb_en: got %b%b want 00", wb_fp_en, wb_int_en); end
    n_cmp++; if (wb_data !== '0 || wb_rd !== '0) begin n_mis++; $display("FAIL reset_wb_bus: got rd=%0d data=%h want 0/0", wb_rd, wb_data); end
    n_cmp++; if (buf_full !== 1'b0 || query_hit !== 1'b0) begin n_mis++; $display("FAIL reset_full_hit: got %b%b want 00", buf_full, query_hit); end
    next_cycle();
    clear = 1'b0;
    sb.delete();
    m_ovf  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_fp_add();
    fpu_sel = 1'b1; fpu_inprogress = 1'b1; fpu_fp_dest = 1'b1; fpu_rd = 5'd3; fpu_result = 32'h4040_0000;
    repeat (7) begin
      mid();
      n_cmp++; if (buf_count !== '0) begin n_mis++; $display("FAIL fp_add_stalled_count: got %0d want 0", buf_count); end
      next_cycle();
    end
    fpu_inprogress = 1'b0;
    mid();
    n_cmp++; if (wb_fp_en !== 1'b0) begin n_mis++; $display("FAIL fp_add_no_bypass: got %b want 0", wb_fp_en); end
    next_cycle();
    fpu_sel = 1'b0;
    mid();
    n_cmp++; if (wb_fp_en !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h4040_0000) begin n_mis++; $display("FAIL fp_add_wb: got en=%b rd=%0d data=%h want 1/3/40400000", wb_fp_en, wb_rd, wb_data); end
    next_cycle();
    mid();
    n_cmp++; if (buf_count !== '0) begin n_mis++; $display("FAIL fp_add_single_push: got %0d want 0", buf_count); end
    next_cycle();
  endtask

  task automatic test_zero_cycle();
    fpu_sel = 1'b1; fpu_inprogress = 1'b0; fpu_fp_dest = 1'b0; fpu_rd = 5'd5; fpu_result = 32'h1234_5678;
    int_port_busy = 1'b1; query_rd = 5'd5; query_fp = 1'b0;
    next_cycle();
    fpu_sel = 1'b0;
    repeat (3) begin
      mid();
      n_cmp++; if (wb_int_en !== 1'b0) begin n_mis++; $display("FAIL zc_int_blocked: got %b want 0", wb_int_en); end
      n_cmp++; if (query_hit !== 1'b1 || query_data !== 32'h1234_5678) begin n_mis++; $display("FAIL zc_fwd_int: got %b/%h want 1/12345678", query_hit, query_data); end
      #2 query_fp = 1'b1;
      #1;
      n_cmp++; if (query_hit !== 1'b0) begin n_mis++; $display("FAIL zc_fwd_fp_miss: got %b want 0", query_hit); end
      query_fp = 1'b0;
      next_cycle();
    end
    int_port_busy = 1'b0;
    mid();
    n_cmp++; if (wb_int_en !== 1'b1 || wb_rd !== 5'd5) begin n_mis++; $display("FAIL zc_int_wb: got en=%b rd=%0d want 1/5", wb_int_en, wb_rd); end
    n_cmp++; if (query_hit !== 1'b1) begin n_mis++; $display("FAIL zc_fwd_during_pop: got %b want 1", query_hit); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    load_fp_wr = 1'b1; fpu_sel = 1'b1; fpu_inprogress = 1'b0; fpu_fp_dest = 1'b1;
    fpu_rd = 5'd1; fpu_result = 32'hAAAA_0001;
    next_cycle();
    fpu_result = 32'hBBBB_0002;
    next_cycle();
    fpu_sel = 1'b0; query_rd = 5'd1; query_fp = 1'b1;
    mid();
    n_cmp++; if (buf_full !== 1'b1 || buf_count !== 2'd2) begin n_mis++; $display("FAIL b2b_full: got full=%b count=%0d want 1/2", buf_full, buf_count); end
    n_cmp++; if (query_hit !== 1'b1 || query_data !== 32'hBBBB_0002) begin n_mis++; $display("FAIL b2b_youngest: got %b/%h want 1/bbbb0002", query_hit, query_data); end
    next_cycle();
    load_fp_wr = 1'b0;
    mid();
    n_cmp++; if (wb_fp_en !== 1'b1 || wb_data !== 32'hAAAA_0001) begin n_mis++; $display("FAIL b2b_pop0: got %b/%h want 1/aaaa0001", wb_fp_en, wb_data); end
    next_cycle();
    mid();
    n_cmp++; if (wb_fp_en !== 1'b1 || wb_data !== 32'hBBBB_0002) begin n_mis++; $display("FAIL b2b_pop1: got %b/%h want 1/bbbb0002", wb_fp_en, wb_data); end
    next_cycle();
  endtask

  task automatic test_full_push();
    load_fp_wr = 1'b1; fpu_sel = 1'b1; fpu_inprogress = 1'b0; fpu_fp_dest = 1'b1;
    fpu_rd = 5'd7; fpu_result = 32'hC0C0_0007;
    next_cycle();
    fpu_rd = 5'd8; fpu_result = 32'hD0D0_0008;
    next_cycle();
    load_fp_wr = 1'b0; fpu_rd = 5'd9; fpu_result = 32'hE0E0_0009;
    mid();
    n_cmp++; if (wb_fp_en !== 1'b1 || wb_data !== 32'hC0C0_0007) begin n_mis++; $display("FAIL full_pushpop_wb: got %b/%h want 1/c0c00007", wb_fp_en, wb_data); end
    next_cycle();
    load_fp_wr = 1'b1; fpu_rd = 5'd10; fpu_result = 32'hF0F0_000A;
    mid();
    n_cmp++; if (buf_count !== 2'd2 || overflow !== 1'b0) begin n_mis++; $display("FAIL full_pushpop_count: got count=%0d ovf=%b want 2/0", buf_count, overflow); end
    next_cycle();
    fpu_sel = 1'b0; query_rd = 5'd9; query_fp = 1'b1;
    mid();
    n_cmp++; if (overflow !== 1'b1 || buf_count !== 2'd2) begin n_mis++; $display("FAIL full_drop: got ovf=%b count=%0d want 1/2", overflow, buf_count); end
    n_cmp++; if (query_hit !== 1'b1 || query_data !== 32'hE0E0_0009) begin n_mis++; $display("FAIL full_fwd_kept: got %b/%h want 1/e0e00009", query_hit, query_data); end
    #2 query_rd = 5'd10;
    #1;
    n_cmp++; if (query_hit !== 1'b0) begin n_mis++; $display("FAIL full_fwd_dropped: got %b want 0", query_hit); end
    next_cycle();
    load_fp_wr = 1'b0;
    mid();
    n_cmp++; if (wb_data !== 32'hD0D0_0008) begin n_mis++; $display("FAIL full_drain0: got %h want d0d00008", wb_data); end
    next_cycle();
    mid();
    n_cmp++; if (wb_data !== 32'hE0E0_0009) begin n_mis++; $display("FAIL full_drain1: got %h want e0e00009", wb_data); end
    next_cycle();
  endtask

  task automatic test_ex_hold();
    fpu_sel = 1'b1; fpu_inprogress = 1'b0; ex_hold = 1'b1; fpu_fp_dest = 1'b1;
    fpu_rd = 5'd12; fpu_result = 32'h3F80_0000;
    repeat (4) begin
      mid();
      n_cmp++; if (buf_count !== '0) begin n_mis++; $display("FAIL hold_no_push: got %0d want 0", buf_count); end
      next_cycle();
    end
    ex_hold = 1'b0;
    next_cycle();
    fpu_sel = 1'b0;
    mid();
    n_cmp++; if (buf_count !== 2'd1 || wb_fp_en !== 1'b1) begin n_mis++; $display("FAIL hold_one_push: got count=%0d en=%b want 1/1", buf_count, wb_fp_en); end
    next_cycle();
    mid();
    n_cmp++; if (buf_count !== '0) begin n_mis++; $display("FAIL hold_drained: got %0d want 0", buf_count); end
    next_cycle();
  endtask

  task automatic test_int_rd0();
    fpu_sel = 1'b1; fpu_inprogress = 1'b0; fpu_fp_dest = 1'b0; fpu_rd = 5'd0; fpu_result = 32'h0000_BEEF;
    query_rd = 5'd0; query_fp = 1'b0;
    next_cycle();
    fpu_sel = 1'b0;
    mid();
    n_cmp++; if (buf_count !== 2'd1 || wb_int_en !== 1'b0) begin n_mis++; $display("FAIL x0_suppressed: got count=%0d en=%b want 1/0", buf_count, wb_int_en); end
    n_cmp++; if (query_hit !== 1'b0) begin n_mis++; $display("FAIL x0_no_fwd: got %b want 0", query_hit); end
    next_cycle();
    mid();
    n_cmp++; if (buf_count !== '0) begin n_mis++; $display("FAIL x0_popped: got %0d want 0", buf_count); end
    next_cycle();
  endtask

  task automatic test_clear();
    load_fp_wr = 1'b1; fpu_sel = 1'b1; fpu_inprogress = 1'b0; fpu_fp_dest = 1'b1;
    fpu_rd = 5'd20; fpu_result = 32'h1111_0014;
    next_cycle();
    fpu_rd = 5'd21; fpu_result = 32'h2222_0015;
    next_cycle();
    fpu_rd = 5'd22; fpu_result = 32'h3333_0016; clear = 1'b1;
    mid();
    n_cmp++; if (buf_count !== 2'd2) begin n_mis++; $display("FAIL clear_pre_count: got %0d want 2", buf_count); end
    next_cycle();
    clear = 1'b0; fpu_sel = 1'b0; load_fp_wr = 1'b0; query_rd = 5'd22; query_fp = 1'b1;
    mid();
    n_cmp++; if (buf_count !== '0 || buf_full !== 1'b0) begin n_mis++; $display("FAIL clear_count: got count=%0d full=%b want 0/0", buf_count, buf_full); end
    n_cmp++; if (wb_fp_en !== 1'b0 || wb_int_en !== 1'b0) begin n_mis++; $display("FAIL clear_wb_en: got %b%b want 00", wb_fp_en, wb_int_en); end
    n_cmp++; if (query_hit !== 1'b0 || query_data !== '0) begin n_mis++; $display("FAIL clear_push_dropped: got %b/%h want 0/0", query_hit, query_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL clear_overflow: got %b want 0", overflow); end
    next_cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      fpu_sel        = ($urandom_range(0, 1) == 1);
      fpu_inprogress = ($urandom_range(0, 9) < 3);
      ex_hold        = ($urandom_range(0, 9) < 2);
      fpu_fp_dest    = ($urandom_range(0, 1) == 1);
      fpu_rd         = RD_W'($urandom_range(0, 3));
      fpu_result     = $urandom;
      load_fp_wr     = ($urandom_range(0, 9) < 4);
      int_port_busy  = ($urandom_range(0, 9) < 4);
      query_rd       = RD_W'($urandom_range(0, 3));
      query_fp       = ($urandom_range(0, 1) == 1);
      clear          = ($urandom_range(0, 49) == 0);
      next_cycle();
    end
    fpu_sel = 1'b0; clear = 1'b0; load_fp_wr = 1'b0; int_port_busy = 1'b0;
    repeat (3) next_cycle();
  endtask

  initial begin
    clear = 1'b1; fpu_sel = 1'b0; fpu_inprogress = 1'b0; ex_hold = 1'b0; fpu_fp_dest = 1'b0;
    fpu_result = '0; fpu_rd = '0; load_fp_wr = 1'b0; int_port_busy = 1'b0; query_rd = '0; query_fp = 1'b0;
    test_reset();
    test_fp_add();
    test_zero_cycle();
    test_back_to_back();
    test_full_push();
    test_ex_hold();
    test_int_rd0();
    test_clear();
    test_random();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
